bit_pos_iter: RTL and testbench

- Parametrised successor to the single-shot lowest-set-bit encoder.
- Accepts a WIDTH-bit mask, such as an Othello legal-move bitboard, over a valid/ready handshake.
- Emits the index of every set bit, lowest first, one per cycle, over a second valid/ready handshake. Each emitted bit is cleared internally as it goes out.
- Sits between move generation and the per-move search/flip pipeline; an empty mask produces a single "none" (pass) beat.

---
 rtl/bit_pos_iter.sv | 127 ++++++++++++
 tb/tb_bit_pos_iter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_pos_iter.sv
// Enumerates the set bits of a WIDTH-bit mask, lowest first, one index per beat.
// Optional beat ordinal output out_seq is enabled by defining BIT_POS_ITER_SEQ_EN.
module bit_pos_iter #(
   parameter  int WIDTH = 64,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_pos,
   output logic             out_last,
   output logic             out_none
`ifdef BIT_POS_ITER_SEQ_EN
   ,
   output logic [IDX_W:0]   out_seq
`endif
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] rem;

   // Folded-OR trailing-zero count: each level asks whether the low half of
   // the remaining window is empty and, if so, shifts it away.
   function automatic logic [IDX_W-1:0] ctz(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] v;
      logic [WIDTH-1:0] lo;
      logic [IDX_W-1:0] idx;
      v   = x;
      idx = '0;
      for (int l = IDX_W - 1; l >= 0; l--) begin
         lo = {WIDTH{1'b1}} >> (WIDTH - (1 << l));
         if ((v & lo) == '0) begin
            idx[l] = 1'b1;
            v      = v >> (1 << l);
         end
      end
      return idx;
   endfunction

   function automatic logic [WIDTH-1:0] drop_lowest(input logic [WIDTH-1:0] x);
      return x & (x - WIDTH'(1));
   endfunction

   logic             accept;
   logic             beat;
   logic [WIDTH-1:0] src;
   logic [WIDTH-1:0] src_rest;
   logic [IDX_W-1:0] src_pos;

   assign in_ready = reset_n & ~out_valid & ~abort;
   assign accept   = in_valid & in_ready;
   assign beat     = out_valid & out_ready;

   // One shared tree: the fresh mask while idle, the remainder while running.
   assign src      = out_valid ? rem : in_mask;
   assign src_rest = drop_lowest(src);
   assign src_pos  = ctz(src);

   // Stage boundary: everything below registers directly onto the outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_pos   <= '0;
         out_last  <= 1'b0;
         out_none  <= 1'b0;
         rem       <= '0;
      end else if (abort) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_none  <= 1'b0;
         rem       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= RUN;
                  out_valid <= 1'b1;
                  out_pos   <= (in_mask == '0) ? '0 : src_pos;
                  rem       <= src_rest;
                  out_last  <= (src_rest == '0);
                  out_none  <= (in_mask == '0);
               end
            end
            RUN: begin
               if (beat) begin
                  if (out_last) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_none  <= 1'b0;
                  end else begin
                     out_pos  <= src_pos;
                     rem      <= src_rest;
                     out_last <= (src_rest == '0);
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef BIT_POS_ITER_SEQ_EN
   always_ff @(posedge clock) begin
      if (!reset_n || abort) begin
         out_seq <= '0;
      end else if (accept) begin
         out_seq <= '0;
      end else if (beat) begin
         out_seq <= out_last ? '0 : out_seq + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bit_pos_iter.sv
// Randomised self-checking bench for bit_pos_iter (64-bit and 16-bit instances)
// against a set-bit list model.
module tb_bit_pos_iter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n, abort, in_valid, in_ready, out_valid, out_ready, out_last, out_none;
   logic [63:0] in_mask;
   logic [5:0]  out_pos;
   logic        abort16, in_valid16, in_ready16, out_valid16, out_ready16, out_last16, out_none16;
   logic [15:0] in_mask16;
   logic [3:0]  out_pos16;
`ifdef BIT_POS_ITER_SEQ_EN
   logic [6:0]  out_seq;
   logic [4:0]  out_seq16;
`endif

   int total  = 0;
   int passed = 0;

   bit_pos_iter #(.WIDTH(64)) dut (
      .clock(clock), .reset_n(reset_n), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
      .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
      .out_last(out_last), .out_none(out_none)
`ifdef BIT_POS_ITER_SEQ_EN
      , .out_seq(out_seq)
`endif
   );

   bit_pos_iter #(.WIDTH(16)) dut16 (
      .clock(clock), .reset_n(reset_n), .abort(abort16),
      .in_valid(in_valid16), .in_ready(in_ready16), .in_mask(in_mask16),
      .out_valid(out_valid16), .out_ready(out_ready16), .out_pos(out_pos16),
      .out_last(out_last16), .out_none(out_none16)
`ifdef BIT_POS_ITER_SEQ_EN
      , .out_seq(out_seq16)
`endif
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drives one mask into the 64-bit DUT and checks every beat against the
   // list of set-bit indices. Stalls the first beat for 'stall' cycles.
   task automatic run_mask(input logic [63:0] m, input int stall, input bit rnd);
      int q[$];
      int n, idx, cyc;
      bit none_e;
      for (int i = 0; i < 64; i++) if (m[i]) q.push_back(i);
      none_e = (m == 64'd0);
      if (none_e) q.push_back(0);
      n = q.size();
      total++; if (in_ready !== 1'b1) $display("FAIL accept_ready: got %b want 1 (mask %h)", in_ready, m); else passed++;
      in_valid = 1'b1;
      in_mask  = m;
      tick();
      in_valid = 1'b0;
      in_mask  = {$urandom, $urandom};
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 400) begin
         out_ready = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         total++; if (out_valid !== 1'b1) $display("FAIL beat_valid: got %b want 1 (mask %h beat %0d)", out_valid, m, idx); else passed++;
         total++; if (out_pos !== 6'(q[idx])) $display("FAIL beat_pos: got %0d want %0d (mask %h)", out_pos, q[idx], m); else passed++;
         total++; if (out_last !== (idx == n - 1)) $display("FAIL beat_last: got %b want %b (mask %h beat %0d)", out_last, (idx == n - 1), m, idx); else passed++;
         total++; if (out_none !== none_e) $display("FAIL beat_none: got %b want %b (mask %h)", out_none, none_e, m); else passed++;
         total++; if (in_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0 (mask %h)", in_ready, m); else passed++;
`ifdef BIT_POS_ITER_SEQ_EN
         total++; if (out_seq !== 7'(idx)) $display("FAIL beat_seq: got %0d want %0d (mask %h)", out_seq, idx, m); else passed++;
`endif
         if (out_ready && out_valid === 1'b1) idx++;
         tick();
         cyc++;
      end
      total++; if (idx != n) $display("FAIL beat_count: got %0d want %0d beats (mask %h)", idx, n, m); else passed++;
      out_ready = 1'b1;
      total++; if (out_valid !== 1'b0) $display("FAIL idle_valid: got %b want 0 (mask %h)", out_valid, m); else passed++;
      total++; if (out_last !== 1'b0 || out_none !== 1'b0) $display("FAIL idle_flags: got last=%b none=%b want 0/0", out_last, out_none); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1 (mask %h)", in_ready, m); else passed++;
`ifdef BIT_POS_ITER_SEQ_EN
      total++; if (out_seq !== 7'd0) $display("FAIL idle_seq: got %0d want 0", out_seq); else passed++;
`endif
   endtask

   task automatic run_mask16(input logic [15:0] m);
      int q[$];
      int n, idx, cyc;
      for (int i = 0; i < 16; i++) if (m[i]) q.push_back(i);
      if (m == 16'd0) q.push_back(0);
      n = q.size();
      in_valid16 = 1'b1;
      in_mask16  = m;
      out_ready16 = 1'b1;
      tick();
      in_valid16 = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 100) begin
         total++; if (out_valid16 !== 1'b1) $display("FAIL w16_valid: got %b want 1 (mask %h)", out_valid16, m); else passed++;
         total++; if (out_pos16 !== 4'(q[idx])) $display("FAIL w16_pos: got %0d want %0d (mask %h)", out_pos16, q[idx], m); else passed++;
         total++; if (out_last16 !== (idx == n - 1)) $display("FAIL w16_last: got %b want %b (mask %h)", out_last16, (idx == n - 1), m); else passed++;
         total++; if (out_none16 !== (m == 16'd0)) $display("FAIL w16_none: got %b want %b (mask %h)", out_none16, (m == 16'd0), m); else passed++;
`ifdef BIT_POS_ITER_SEQ_EN
         total++; if (out_seq16 !== 5'(idx)) $display("FAIL w16_seq: got %0d want %0d", out_seq16, idx); else passed++;
`endif
         if (out_valid16 === 1'b1) idx++;
         tick();
         cyc++;
      end
      total++; if (idx != n) $display("FAIL w16_count: got %0d want %0d beats (mask %h)", idx, n, m); else passed++;
      total++; if (out_valid16 !== 1'b0) $display("FAIL w16_idle: got %b want 0", out_valid16); else passed++;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      in_valid = 1'b1;
      in_mask  = 64'h0000_0000_0000_00FF;
      tick();
      tick();
      total++; if (in_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passed++;
      total++; if (out_pos !== 6'd0) $display("FAIL rst_pos: got %0d want 0", out_pos); else passed++;
      total++; if (out_last !== 1'b0 || out_none !== 1'b0) $display("FAIL rst_flags: got last=%b none=%b want 0/0", out_last, out_none); else passed++;
      total++; if (out_valid16 !== 1'b0 || in_ready16 !== 1'b0) $display("FAIL rst_w16: got valid=%b ready=%b want 0/0", out_valid16, in_ready16); else passed++;
`ifdef BIT_POS_ITER_SEQ_EN
      total++; if (out_seq !== 7'd0) $display("FAIL rst_seq: got %0d want 0", out_seq); else passed++;
`endif
      in_valid = 1'b0;
      reset_n  = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL rst_release_valid: got %b want 0", out_valid); else passed++;
   endtask

   task automatic test_directed();
      run_mask(64'h8000_0000_0000_0811, 0, 1'b0);
      run_mask(64'h0000_0000_0000_0000, 0, 1'b0);
      run_mask(64'h0000_0000_0000_0006, 3, 1'b0);
      run_mask(64'h8000_0000_0000_0000, 0, 1'b0);
      run_mask(64'h0000_0000_0000_00A0, 0, 1'b0);
   endtask

   task automatic test_abort();
      in_valid  = 1'b1;
      in_mask   = 64'hFFFF_FFFF_FFFF_FFFF;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         total++; if (out_pos !== 6'(b) || out_valid !== 1'b1) $display("FAIL abort_pre_beat: got pos=%0d valid=%b want %0d/1", out_pos, out_valid, b); else passed++;
         tick();
      end
      total++; if (out_pos !== 6'd4) $display("FAIL abort_fifth_beat: got %0d want 4", out_pos); else passed++;
      abort    = 1'b1;
      in_valid = 1'b1;
      in_mask  = 64'h0000_0000_0000_0030;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL abort_ready: got %b want 0", in_ready); else passed++;
      tick();
      abort = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", out_valid); else passed++;
      total++; if (out_last !== 1'b0 || out_none !== 1'b0) $display("FAIL abort_flags: got last=%b none=%b want 0/0", out_last, out_none); else passed++;
`ifdef BIT_POS_ITER_SEQ_EN
      total++; if (out_seq !== 7'd0) $display("FAIL abort_seq: got %0d want 0", out_seq); else passed++;
`endif
      run_mask(64'h0000_0000_0000_0030, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      in_valid  = 1'b1;
      in_mask   = 64'h0000_0000_0000_F0F0;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      total++; if (out_valid !== 1'b0 || out_pos !== 6'd0) $display("FAIL midrst_out: got valid=%b pos=%0d want 0/0", out_valid, out_pos); else passed++;
      reset_n = 1'b1;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL midrst_no_beats: got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", in_ready); else passed++;
   endtask

   task automatic test_random();
      logic [63:0] m;
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 4))
            0:       m = 64'd0;
            1:       m = 64'd1 << $urandom_range(0, 63);
            2:       m = {$urandom, $urandom};
            3:       m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            default: m = (64'd1 << 63) | ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
         endcase
         run_mask(m, $urandom_range(0, 2), 1'b1);
      end
   endtask

   task automatic test_width16();
      run_mask16(16'h8001);
      run_mask16(16'h0000);
      for (int t = 0; t < 8; t++) run_mask16(16'($urandom));
   endtask

   initial begin
      reset_n     = 1'b0;
      abort       = 1'b0;
      in_valid    = 1'b0;
      in_mask     = 64'd0;
      out_ready   = 1'b0;
      abort16     = 1'b0;
      in_valid16  = 1'b0;
      in_mask16   = 16'd0;
      out_ready16 = 1'b0;
      test_reset();
      test_directed();
      test_abort();
      test_reset_mid();
      test_random();
      test_width16();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
